// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the memory word into IF/ID,
// and handles decode stalls, taken-branch flushes and the end-of-program halt.
module fetch_stage #(
   parameter logic [15:0] LAST_PC = 16'd10,
   parameter logic [15:0] NOP     = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] pc_out,
   input  logic [15:0] instr_in,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc1,
   output logic        if_id_valid,
   output logic        halted,
   output logic [15:0] fetch_count
);

   localparam int unsigned W = 16;

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   pc_nxt;
   logic [W-1:0]   instr_nxt;
   logic [W-1:0]   pc1_nxt;
   logic           valid_nxt;
   logic [W-1:0]   count_nxt;
   logic [W-1:0]   pc_inc;

   assign pc_inc = W'(pc_out + W'(1));

   // Next-state and next-register values; branch outranks stall outranks advance.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_out;
      instr_nxt = if_id_instr;
      pc1_nxt   = if_id_pc1;
      valid_nxt = if_id_valid;
      count_nxt = fetch_count;
      if (branch_taken) begin
         pc_nxt    = branch_target;
         instr_nxt = NOP;
         pc1_nxt   = '0;
         valid_nxt = 1'b0;
         state_nxt = RUN;
      end else if (!stall) begin
         case (state)
            RUN: begin
               instr_nxt = instr_in;
               pc1_nxt   = pc_inc;
               valid_nxt = 1'b1;
               pc_nxt    = pc_inc;
               if (fetch_count != '1)
                  count_nxt = W'(fetch_count + W'(1));
               if (pc_out == LAST_PC)
                  state_nxt = HALT;
            end
            HALT: begin
               instr_nxt = NOP;
               valid_nxt = 1'b0;
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         pc_out      <= '0;
         if_id_instr <= NOP;
         if_id_pc1   <= '0;
         if_id_valid <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_nxt;
         pc_out      <= pc_nxt;
         if_id_instr <= instr_nxt;
         if_id_pc1   <= pc1_nxt;
         if_id_valid <= valid_nxt;
         fetch_count <= count_nxt;
      end
   end

   assign halted = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free run, stall, branch, halt, wrap and reset.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc_out;
   logic [15:0] instr_in;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc1;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_count;

   int checks   = 0;
   int failures = 0;

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .pc_out       (pc_out),
      .instr_in     (instr_in),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .if_id_instr  (if_id_instr),
      .if_id_pc1    (if_id_pc1),
      .if_id_valid  (if_id_valid),
      .halted       (halted),
      .fetch_count  (fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'd0:   mem_word = 16'hB683;
         16'd1:   mem_word = 16'h1201;
         16'd2:   mem_word = 16'h2302;
         16'd3:   mem_word = 16'h3403;
         16'd4:   mem_word = 16'hC105;
         16'd5:   mem_word = 16'h4505;
         16'd6:   mem_word = 16'h5606;
         16'd7:   mem_word = 16'h6707;
         16'd8:   mem_word = 16'h7808;
         16'd9:   mem_word = 16'h8909;
         16'd10:  mem_word = 16'h9A0A;
         16'd11:  mem_word = 16'hAB0B;
         16'hFFFF: mem_word = 16'hDEAD;
         default: mem_word = 16'hEEEE;
      endcase
   endfunction

   assign instr_in = mem_word(pc_out);

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                            input logic [15:0] pc1, input logic v, input logic h,
                            input logic [15:0] cnt);
      check({tag, ".pc"},    pc_out, pc);
      check({tag, ".instr"}, if_id_instr, ins);
      check({tag, ".pc1"},   if_id_pc1, pc1);
      check({tag, ".valid"}, 16'(if_id_valid), 16'(v));
      check({tag, ".halt"},  16'(halted), 16'(h));
      check({tag, ".count"}, fetch_count, cnt);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'd0;
      tick(); tick();
      check_all("reset", 16'd0, 16'h0000, 16'd0, 1'b0, 1'b0, 16'd0);

      rst = 1'b0;
      tick();
      check_all("first", 16'd1, 16'hB683, 16'd1, 1'b1, 1'b0, 16'd1);
      tick();
      check_all("second", 16'd2, 16'h1201, 16'd2, 1'b1, 1'b0, 16'd2);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("stall", 16'd2, 16'h1201, 16'd2, 1'b1, 1'b0, 16'd2);
      end
      stall = 1'b0;
      tick();
      check_all("unstall", 16'd3, 16'h2302, 16'd3, 1'b1, 1'b0, 16'd3);
      tick();
      tick();
      check_all("pre_br", 16'd5, 16'hC105, 16'd5, 1'b1, 1'b0, 16'd5);

      branch_taken = 1'b1; branch_target = 16'd7;
      tick();
      check_all("flush", 16'd7, 16'h0000, 16'd0, 1'b0, 1'b0, 16'd5);
      branch_taken = 1'b0;
      tick();
      check_all("target", 16'd8, 16'h6707, 16'd8, 1'b1, 1'b0, 16'd6);

      tick(); tick();
      check_all("pre_last", 16'd10, 16'h8909, 16'd10, 1'b1, 1'b0, 16'd8);
      tick();
      check_all("last", 16'd11, 16'h9A0A, 16'd11, 1'b1, 1'b1, 16'd9);
      tick();
      check_all("halt", 16'd11, 16'h0000, 16'd11, 1'b0, 1'b1, 16'd9);

      branch_taken = 1'b1; branch_target = 16'd5;
      tick();
      check_all("unhalt", 16'd5, 16'h0000, 16'd0, 1'b0, 1'b0, 16'd9);
      branch_taken = 1'b0;
      tick();
      check_all("resume", 16'd6, 16'h4505, 16'd6, 1'b1, 1'b0, 16'd10);

      stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0003;
      tick();
      check_all("br_stall", 16'd3, 16'h0000, 16'd0, 1'b0, 1'b0, 16'd10);

      stall = 1'b0; branch_taken = 1'b1; branch_target = 16'hFFFF;
      tick();
      branch_taken = 1'b0;
      tick();
      check_all("wrap", 16'd0, 16'hDEAD, 16'd0, 1'b1, 1'b0, 16'd11);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      stall = 1'b1;
      tick();
      check_all("stall6", 16'd6, 16'h4505, 16'd6, 1'b1, 1'b0, 16'd6);
      rst = 1'b1; branch_taken = 1'b1; branch_target = 16'd9;
      tick();
      check_all("mid_rst", 16'd0, 16'h0000, 16'd0, 1'b0, 1'b0, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
